pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Power-up and recovery sequencer for the 3-output clock PLL (20/25/125 MHz from 50 MHz refclk).
//  - Pulses the PLL reset and waits for lock, then qualifies lock as stable.
//  - Releases per-output-domain reset requests in staggered order.
//  - Re-runs the sequence on lock loss or software request; retries a bounded number of times.
//  - Runs entirely on refclk. Each downstream domain synchronises its own domain_rst bit.
// PARAMETERS
//  RST_CYCLES    16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT  50000  refclk cycles to wait for lock before a retry (1 ms @ 50 MHz)
//  STABLE_CYCLES 1024   consecutive synchronised-locked cycles required before release
//  STAGGER       8      refclk cycles between successive domain reset releases (>=1)
//  N_DOMAINS     3      number of domain reset outputs (1..8)
//  MAX_RETRIES   3      failed lock attempts before FAIL (1..15)
// PORTS
//  refclk      in   1          50 MHz reference clock; sole clock
//  rst         in   1          asynchronous, active-high reset
//  pll_locked  in   1          PLL locked output, asynchronous to refclk
//  relock_req  in   1          1-cycle request to re-run the sequence (synchronous to refclk)
//  pll_rst     out  1          PLL reset, active-high
//  domain_rst  out  N_DOMAINS  per-domain reset requests, active-high; bit i = outclk_i domain
//  clk_rdy     out  1          high only in RUN
//  lock_lost   out  1          1-cycle pulse when lock drops in RUN
//  fail        out  1          high in FAIL
//  retry_cnt   out  4          failed attempts since last RUN or relock_req
// BEHAVIOUR
//  Reset values (rst high, async):
//  - state=RST_PLL, cycle counter=0, pll_rst=1, domain_rst=all 1s.
//  - clk_rdy=0, lock_lost=0, fail=0, retry_cnt=0, sync flops=0.
//  Registers and outputs:
//  - pll_locked passes through a 2-flop synchroniser to give locked_s (2-cycle latency).
//  - All outputs are registered. Each value below is the one present while in the named state.
//  - One shared counter (ctr) is sized with $clog2 of the largest timed parameter.
//  - ctr clears on every state entry.
//  RST_PLL:   pll_rst=1, domain_rst=all 1s.
//             When ctr==RST_CYCLES-1, go to WAIT_LOCK.
//  WAIT_LOCK: pll_rst=0.
//             If locked_s=1, go to STABILIZE.
//             Else if ctr==LOCK_TIMEOUT-1, increment retry_cnt; go to FAIL when the new value
//             equals MAX_RETRIES, otherwise go to RST_PLL.
//  STABILIZE: If locked_s=0, return to WAIT_LOCK (timeout restarts, no retry counted).
//             When ctr==STABLE_CYCLES-1 with locked_s=1, go to RELEASE.
//  RELEASE:   domain_rst[i] clears when ctr==i*STAGGER (bit 0 on the entry cycle).
//             When ctr==(N_DOMAINS-1)*STAGGER, go to RUN.
//             If locked_s=0, set lock_lost=0, reassert all domain_rst and go to RST_PLL.
//  RUN:       clk_rdy=1, retry_cnt=0.
//             If locked_s=0, pulse lock_lost for one cycle, go to RST_PLL.
//             Else if relock_req=1, go to RST_PLL without lock_lost.
//             On exit, clk_rdy=0 and domain_rst=all 1s on the same clock edge as the state change.
//  FAIL:      pll_rst=1, domain_rst=all 1s, fail=1, retry_cnt holds.
//             Only relock_req leaves FAIL: go to RST_PLL with retry_cnt=0 and fail=0.
//  relock_req in WAIT_LOCK, STABILIZE or RELEASE: go to RST_PLL, reassert domain_rst,
//             retry_cnt unchanged. relock_req in RST_PLL is ignored.
//  Priority: lock loss beats relock_req; timeout is evaluated only when locked_s=0.
//  domain_rst bits never clear outside RELEASE. Once cleared, they stay clear until the exit
//  from RUN or RELEASE.
//  rst mid-sequence returns everything to the reset values immediately.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGGER=2, N_DOMAINS=3, MAX_RETRIES=2)
//  1. Release rst; raise pll_locked 5 cycles after pll_rst falls.
//     -> pll_rst high exactly 4 cycles; domain_rst goes 111->110->100->000 at 2-cycle spacing;
//        clk_rdy=1.
//  2. Keep pll_locked low.
//     -> two 20-cycle timeouts; retry_cnt 1 then 2; fail=1, pll_rst=1.
//     Then pulse relock_req and give lock -> retry_cnt=0, fail=0, reaches RUN.
//  3. Glitch pll_locked low for 3 cycles midway through STABILIZE.
//     -> returns to WAIT_LOCK, then needs 8 fresh stable cycles; retry_cnt unchanged.
//  4. Drop pll_locked in RUN.
//     -> lock_lost is a 1-cycle pulse; domain_rst=111 and clk_rdy=0 on the same edge;
//        pll_rst=1 for 4 cycles; sequence repeats.
//  5. Pulse relock_req in RUN and again in RELEASE after bit 0 cleared.
//     -> domain_rst back to 111, lock_lost stays 0.
//  6. Assert rst in RELEASE.
//     -> all outputs return to their reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Power-up and recovery sequencer for the refclk-driven clock PLL: pulses the PLL reset,
// qualifies lock, then releases the per-domain resets one after another.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGGER       = 8,
    parameter int N_DOMAINS     = 3,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 relock_req,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] domain_rst,
    output logic                 clk_rdy,
    output logic                 lock_lost,
    output logic                 fail,
    output logic [3:0]           retry_cnt
);

    localparam int REL_LAST = (N_DOMAINS - 1) * STAGGER;
    localparam int MAX_A    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B    = (STABLE_CYCLES > REL_LAST + 1) ? STABLE_CYCLES : REL_LAST + 1;
    localparam int MAX_T    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CTR_W    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CTR_W-1:0]     RST_LAST_C     = CTR_W'(RST_CYCLES - 1);
    localparam logic [CTR_W-1:0]     TIMEOUT_LAST_C = CTR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CTR_W-1:0]     STABLE_LAST_C  = CTR_W'(STABLE_CYCLES - 1);
    localparam logic [CTR_W-1:0]     REL_LAST_C     = CTR_W'(REL_LAST);
    localparam logic [3:0]           MAX_RETRY_C    = 4'(MAX_RETRIES);
    localparam logic [N_DOMAINS-1:0] DOM_ALL        = '1;
    localparam logic [N_DOMAINS-1:0] DOM_FIRST      = ~(N_DOMAINS'(1));

    typedef enum logic [2:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t               r_state;
    logic [CTR_W-1:0]     r_ctr;
    logic [1:0]           r_sync;
    logic                 r_pll_rst;
    logic [N_DOMAINS-1:0] r_domain_rst;
    logic                 r_clk_rdy;
    logic                 r_lock_lost;
    logic                 r_fail;
    logic [3:0]           r_retry_cnt;

    logic                 w_locked_s;
    logic [CTR_W-1:0]     w_ctr_inc;
    logic [3:0]           w_retry_inc;
    logic [N_DOMAINS-1:0] w_rel_mask;
    logic                 w_restart;
    logic                 w_lost;

    assign w_locked_s  = r_sync[1];
    assign w_ctr_inc   = r_ctr + 1'b1;
    assign w_retry_inc = r_retry_cnt + 4'd1;

    // Bit i drops on the edge that moves the RELEASE counter onto i*STAGGER; bit 0 drops on entry.
    for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_rel
        assign w_rel_mask[gi] = (gi != 0) && (w_ctr_inc == CTR_W'(gi * STAGGER));
    end

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_restart = 1'b0;
        w_lost    = 1'b0;
        case (r_state)
            S_WAIT_LOCK: w_restart = relock_req;
            S_STABILIZE: w_restart = relock_req && w_locked_s;
            S_RELEASE:   w_restart = relock_req || !w_locked_s;
            S_RUN: begin
                w_restart = relock_req || !w_locked_s;
                w_lost    = !w_locked_s;
            end
            S_FAIL:      w_restart = relock_req;
            default:     w_restart = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RST_PLL;
            r_ctr        <= '0;
            r_sync       <= '0;
            r_pll_rst    <= 1'b1;
            r_domain_rst <= DOM_ALL;
            r_clk_rdy    <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_fail       <= 1'b0;
            r_retry_cnt  <= '0;
        end else begin
            r_sync      <= {r_sync[0], pll_locked};
            r_lock_lost <= 1'b0;
            if (w_restart) begin
                r_state      <= S_RST_PLL;
                r_ctr        <= '0;
                r_pll_rst    <= 1'b1;
                r_domain_rst <= DOM_ALL;
                r_clk_rdy    <= 1'b0;
                r_lock_lost  <= w_lost;
                r_fail       <= 1'b0;
                if (r_state == S_FAIL) begin
                    r_retry_cnt <= '0;
                end
            end else begin
                case (r_state)
                    S_RST_PLL: begin
                        if (r_ctr == RST_LAST_C) begin
                            r_state   <= S_WAIT_LOCK;
                            r_ctr     <= '0;
                            r_pll_rst <= 1'b0;
                        end else begin
                            r_ctr <= w_ctr_inc;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (w_locked_s) begin
                            r_state <= S_STABILIZE;
                            r_ctr   <= '0;
                        end else if (r_ctr == TIMEOUT_LAST_C) begin
                            r_retry_cnt <= w_retry_inc;
                            r_ctr       <= '0;
                            r_pll_rst   <= 1'b1;
                            if (w_retry_inc == MAX_RETRY_C) begin
                                r_state <= S_FAIL;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state <= S_RST_PLL;
                            end
                        end else begin
                            r_ctr <= w_ctr_inc;
                        end
                    end
                    S_STABILIZE: begin
                        if (!w_locked_s) begin
                            r_state <= S_WAIT_LOCK;
                            r_ctr   <= '0;
                        end else if (r_ctr == STABLE_LAST_C) begin
                            r_state      <= S_RELEASE;
                            r_ctr        <= '0;
                            r_domain_rst <= DOM_FIRST;
                        end else begin
                            r_ctr <= w_ctr_inc;
                        end
                    end
                    S_RELEASE: begin
                        if (r_ctr == REL_LAST_C) begin
                            r_state     <= S_RUN;
                            r_ctr       <= '0;
                            r_clk_rdy   <= 1'b1;
                            r_retry_cnt <= '0;
                        end else begin
                            r_ctr        <= w_ctr_inc;
                            r_domain_rst <= r_domain_rst & ~w_rel_mask;
                        end
                    end
                    default: r_ctr <= r_ctr;
                endcase
            end
        end
    end

    assign pll_rst    = r_pll_rst;
    assign domain_rst = r_domain_rst;
    assign clk_rdy    = r_clk_rdy;
    assign lock_lost  = r_lock_lost;
    assign fail       = r_fail;
    assign retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/elapsed-time reference model predicts the
// outputs after every edge; a negedge monitor pops and compares them against the DUT.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int STAGGER       = 2;
    localparam int N_DOMAINS     = 3;
    localparam int MAX_RETRIES   = 2;

    typedef struct packed {
        logic                 pll_rst;
        logic [N_DOMAINS-1:0] domain_rst;
        logic                 clk_rdy;
        logic                 lock_lost;
        logic                 fail;
        logic [3:0]           retry_cnt;
    } out_t;

    typedef enum int {M_RST, M_WAIT, M_STAB, M_REL, M_RUN, M_FAIL} phase_t;

    logic                 refclk;
    logic                 rst;
    logic                 pll_locked;
    logic                 relock_req;
    logic                 pll_rst;
    logic [N_DOMAINS-1:0] domain_rst;
    logic                 clk_rdy;
    logic                 lock_lost;
    logic                 fail;
    logic [3:0]           retry_cnt;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .STAGGER      (STAGGER),
        .N_DOMAINS    (N_DOMAINS),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .domain_rst(domain_rst),
        .clk_rdy   (clk_rdy),
        .lock_lost (lock_lost),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    out_t dut_out;
    always_comb begin
        dut_out.pll_rst    = pll_rst;
        dut_out.domain_rst = domain_rst;
        dut_out.clk_rdy    = clk_rdy;
        dut_out.lock_lost  = lock_lost;
        dut_out.fail       = fail;
        dut_out.retry_cnt  = retry_cnt;
    end

    int   n_checks = 0;
    int   n_errors = 0;
    out_t exp_q[$];

    // Reference model: which phase we are in, how long we have been there, retries so far.
    phase_t m_phase;
    int     m_t;
    int     m_retry;
    logic   m_lost;
    logic   m_s0, m_s1;

    // PLL plant: locks p_delay cycles after its reset falls, with optional short glitches.
    logic p_lk;
    int   p_since, p_delay, p_glitch, p_dmin, p_dmax;

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got pll_rst=%b dom=%b rdy=%b lost=%b fail=%b retry=%0d, expected pll_rst=%b dom=%b rdy=%b lost=%b fail=%b retry=%0d",
                     name, $time, act.pll_rst, act.domain_rst, act.clk_rdy, act.lock_lost, act.fail,
                     act.retry_cnt, exp.pll_rst, exp.domain_rst, exp.clk_rdy, exp.lock_lost, exp.fail,
                     exp.retry_cnt);
        end
    endtask

    task automatic model_reset();
        m_phase = M_RST;
        m_t     = 0;
        m_retry = 0;
        m_lost  = 1'b0;
        m_s0    = 1'b0;
        m_s1    = 1'b0;
    endtask

    task automatic go(input phase_t ph);
        m_phase = ph;
        m_t     = 0;
    endtask

    task automatic model_step(input logic lk, input logic rq);
        logic ls;
        if (rst) begin
            model_reset();
            return;
        end
        ls     = m_s1;
        m_s1   = m_s0;
        m_s0   = lk;
        m_lost = 1'b0;
        case (m_phase)
            M_RST:  if (m_t == RST_CYCLES - 1) go(M_WAIT); else m_t++;
            M_WAIT: begin
                if (rq) go(M_RST);
                else if (ls) go(M_STAB);
                else if (m_t == LOCK_TIMEOUT - 1) begin
                    m_retry++;
                    go(m_retry == MAX_RETRIES ? M_FAIL : M_RST);
                end else m_t++;
            end
            M_STAB: begin
                if (!ls) go(M_WAIT);
                else if (rq) go(M_RST);
                else if (m_t == STABLE_CYCLES - 1) go(M_REL);
                else m_t++;
            end
            M_REL: begin
                if (!ls || rq) go(M_RST);
                else if (m_t == (N_DOMAINS - 1) * STAGGER) begin
                    m_retry = 0;
                    go(M_RUN);
                end else m_t++;
            end
            M_RUN: begin
                if (!ls) begin
                    m_lost = 1'b1;
                    go(M_RST);
                end else if (rq) go(M_RST);
            end
            default: if (rq) begin
                m_retry = 0;
                go(M_RST);
            end
        endcase
    endtask

    function automatic out_t model_out();
        out_t o;
        o.pll_rst = (m_phase == M_RST) || (m_phase == M_FAIL);
        for (int i = 0; i < N_DOMAINS; i++)
            o.domain_rst[i] = !((m_phase == M_RUN) || (m_phase == M_REL && m_t >= i * STAGGER));
        o.clk_rdy   = (m_phase == M_RUN);
        o.lock_lost = m_lost;
        o.fail      = (m_phase == M_FAIL);
        o.retry_cnt = 4'(m_retry);
        return o;
    endfunction

    task automatic plant_step(input int drop_den);
        out_t e;
        e = model_out();
        if (e.pll_rst) begin
            p_lk     = 1'b0;
            p_since  = 0;
            p_glitch = 0;
            p_delay  = $urandom_range(p_dmax, p_dmin);
        end else begin
            p_since++;
            if (p_glitch > 0) begin
                p_glitch--;
                if (p_glitch == 0) p_lk = 1'b1;
            end else if (!p_lk) begin
                if (p_since >= p_delay) p_lk = 1'b1;
            end else if (drop_den > 0 && $urandom_range(drop_den - 1) == 0) begin
                p_lk     = 1'b0;
                p_glitch = $urandom_range(4, 1);
            end
        end
    endtask

    // Drive one edge; the model's prediction for that edge goes onto the scoreboard.
    task automatic cycle(input logic lk, input logic rq);
        pll_locked = lk;
        relock_req = rq;
        @(posedge refclk);
        model_step(lk, rq);
        #1;
        exp_q.push_back(model_out());
    endtask

    task automatic segment(input int ncyc, input int dmin, input int dmax,
                           input int drop_den, input int rq_den);
        logic rq;
        p_dmin = dmin;
        p_dmax = dmax;
        for (int i = 0; i < ncyc; i++) begin
            plant_step(drop_den);
            rq = (rq_den > 0) && ($urandom_range(rq_den - 1) == 0);
            cycle(p_lk, rq);
        end
    endtask

    task automatic run_until(input phase_t ph, input int t, input int max_cyc);
        int n;
        n = 0;
        while (!(m_phase == ph && m_t == t) && n < max_cyc) begin
            plant_step(0);
            cycle(p_lk, 1'b0);
            n++;
        end
        if (n >= max_cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL reach_phase_%0d: not reached within %0d cycles, required phase %0d at t=%0d",
                     ph, max_cyc, ph, t);
        end
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(negedge refclk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cycle", dut_out, e);
            end
        end
    end

    initial begin : stimulus
        rst        = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        p_lk = 1'b0; p_since = 0; p_delay = 0; p_glitch = 0; p_dmin = 5; p_dmax = 5;
        model_reset();
        #2 rst = 1'b1;
        #1 check("reset_values", dut_out, model_out());
        repeat (3) cycle(1'b0, 1'b0);
        rst = 1'b0;

        // Clean power-up, then a lock drop while running.
        segment(60, 5, 5, 0, 0);
        repeat (3) cycle(1'b0, 1'b0);
        segment(60, 5, 5, 0, 0);

        // Never locks: two timeouts into FAIL, then a relock request recovers.
        segment(120, 100, 100, 0, 0);
        cycle(1'b0, 1'b1);
        segment(60, 3, 3, 0, 0);

        // Relock in RUN, then again in RELEASE after bit 0 has cleared.
        cycle(p_lk, 1'b1);
        run_until(M_REL, 1, 100);
        cycle(p_lk, 1'b1);
        segment(60, 4, 4, 0, 0);

        // Three-cycle lock glitch midway through STABILIZE.
        cycle(p_lk, 1'b1);
        run_until(M_STAB, 3, 100);
        repeat (3) cycle(1'b0, 1'b0);
        segment(40, 3, 3, 0, 0);

        // Asynchronous reset in the middle of RELEASE.
        cycle(p_lk, 1'b1);
        run_until(M_REL, 1, 100);
        rst = 1'b1;
        #1;
        model_reset();
        exp_q[$] = model_out();
        check("async_rst", dut_out, model_out());
        repeat (2) begin
            plant_step(0);
            cycle(p_lk, 1'b0);
        end
        rst = 1'b0;
        segment(60, 2, 2, 0, 0);

        // Randomised lock delays, glitches and relock requests.
        segment(4000, 0, 30, 60, 80);

        repeat (2) @(negedge refclk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
